// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide,
// one iteration per cycle, with registered register-file writeback outputs.
module muldiv_unit #(
  parameter bit DIV_FAST_ZERO = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [4:0]  RD_ADDR,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [4:0]  WB_ADDR,
  output logic        WB_EN
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_raw_q, opnd_q;
  logic [2*XLEN-1:0] acc_q, step_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q, neg_q, neg_r_q, dz_q;

  // Operand decode at accept time
  logic            in_a_neg, in_b_neg, in_div_zero, in_ovf, in_fast;
  logic [XLEN-1:0] in_a_mag, in_b_mag, in_special;

  always_comb begin
    in_a_neg    = RS1_DATA[XLEN-1] && (FUNCT3 == 3'b001 || FUNCT3 == 3'b010 ||
                                       FUNCT3 == 3'b100 || FUNCT3 == 3'b110);
    in_b_neg    = RS2_DATA[XLEN-1] && (FUNCT3 == 3'b001 || FUNCT3 == 3'b100 ||
                                       FUNCT3 == 3'b110);
    in_a_mag    = in_a_neg ? (~RS1_DATA + XLEN'(1)) : RS1_DATA;
    in_b_mag    = in_b_neg ? (~RS2_DATA + XLEN'(1)) : RS2_DATA;
    in_div_zero = FUNCT3[2] && (RS2_DATA == '0);
    in_ovf      = FUNCT3[2] && !FUNCT3[0] && (RS1_DATA == 32'h8000_0000) &&
                  (RS2_DATA == 32'hFFFF_FFFF);
    in_fast     = DIV_FAST_ZERO && (in_div_zero || in_ovf);
    if (in_div_zero) in_special = FUNCT3[1] ? RS1_DATA : 32'hFFFF_FFFF;
    else             in_special = FUNCT3[1] ? 32'h0 : 32'h8000_0000;
  end

  // One iteration: multiply uses acc = {partial, multiplier}, divide uses acc = {rem, quotient}
  logic [XLEN:0] mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!op_q[2])
      step_nxt = {mul_sum, acc_q[XLEN-1:1]};
    else if (div_diff[XLEN])
      step_nxt = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      step_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and result selection once all iterations are complete
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   quo, rem, fin_result;

  always_comb begin
    mul_prod = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    quo      = neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem      = neg_r_q ? (~acc_q[2*XLEN-1:XLEN] + XLEN'(1)) : acc_q[2*XLEN-1:XLEN];
    fin_result = '0;
    case (op_q)
      3'b000:          fin_result = mul_prod[XLEN-1:0];
      3'b100, 3'b101:  fin_result = dz_q ? 32'hFFFF_FFFF : quo;
      3'b110, 3'b111:  fin_result = dz_q ? a_raw_q : rem;
      default:         fin_result = mul_prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          accept  = 1'b1;
          state_d = in_fast ? FINISH : CALC;
        end
      end
      CALC:    if (last_q) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; the extra CALC cycle after iteration 31 applies sign fix-up
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q    <= '0;
      a_raw_q <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      WB_EN   <= 1'b0;
      RESULT  <= '0;
      WB_ADDR <= '0;
    end else begin
      if (accept) begin
        op_q    <= FUNCT3;
        a_raw_q <= RS1_DATA;
        opnd_q  <= in_b_mag;
        acc_q   <= {{XLEN{1'b0}}, in_a_mag};
        cnt_q   <= '0;
        last_q  <= 1'b0;
        neg_q   <= in_a_neg ^ in_b_neg;
        neg_r_q <= in_a_neg;
        dz_q    <= in_div_zero;
        WB_ADDR <= RD_ADDR;
      end else if (state_q == CALC && !last_q) begin
        acc_q <= step_nxt;
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(31)) last_q <= 1'b1;
      end
      if (state_d == FINISH && state_q != FINISH)
        RESULT <= (state_q == IDLE) ? in_special : fin_result;
      BUSY  <= (state_d != IDLE);
      DONE  <= (state_d == FINISH);
      WB_EN <= (state_d == FINISH) &&
               (((state_q == IDLE) ? RD_ADDR : WB_ADDR) != '0);
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results come from a behavioural
// RV32M model or fixed vectors and are compared when DONE pulses.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [2:0]  FUNCT3;
  logic [31:0] RS1_DATA, RS2_DATA;
  logic [4:0]  RD_ADDR;
  logic        BUSY, DONE, WB_EN;
  logic [31:0] RESULT;
  logic [4:0]  WB_ADDR;

  muldiv_unit dut (
    .CLK(CLK), .RST(RST), .START(START), .FUNCT3(FUNCT3),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .RD_ADDR(RD_ADDR),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .WB_ADDR(WB_ADDR), .WB_EN(WB_EN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  addr;
    logic        wb;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb2;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (op)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = 64'(sa * sb2); return p[63:32]; end
      3'b010: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb2);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb2);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Completion monitor: every DONE must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (DONE) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(DONE), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",   64'(RESULT),  64'(e.res));
        check("wb_addr",  64'(WB_ADDR), 64'(e.addr));
        check("wb_en",    64'(WB_EN),   64'(e.wb));
        check("latency",  64'(cyc),     64'(e.cyc));
      end
    end else begin
      check("wb_en_idle", 64'(WB_EN), 64'(0));
    end
  end

  // Wait for IDLE, drive one op, push its expectation, then scramble inputs
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res);
    exp_t e;
    @(negedge CLK);
    for (int i = 0; i < 100 && BUSY; i++) @(negedge CLK);
    if (BUSY) check("idle_timeout", 64'(BUSY), 64'(0));
    FUNCT3 = op; RS1_DATA = a; RS2_DATA = b; RD_ADDR = rd; START = 1'b1;
    e.res  = exp_res;
    e.addr = rd;
    e.wb   = (rd != 0);
    e.cyc  = cyc + 1 + (is_fast(op, a, b) ? 0 : 33);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    START = 1'b0;
    RS1_DATA = $urandom; RS2_DATA = $urandom; FUNCT3 = 3'($urandom); RD_ADDR = 5'($urandom);
  endtask

  task automatic issue_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    issue(op, a, b, rd, ref_result(op, a, b));
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] t [5];
    t = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    return ($urandom_range(0, 2) == 0) ? t[$urandom_range(0, 4)] : $urandom;
  endfunction

  initial begin
    RST = 1'b1; START = 1'b0; FUNCT3 = '0; RS1_DATA = '0; RS2_DATA = '0; RD_ADDR = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy",    64'(BUSY),    64'(0));
    check("rst_done",    64'(DONE),    64'(0));
    check("rst_result",  64'(RESULT),  64'(0));
    check("rst_wb_addr", 64'(WB_ADDR), 64'(0));
    RST = 1'b0;

    // Fixed vectors
    issue(3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF);
    issue(3'b101, 32'd100,       32'd7,         5'd7,  32'd14);
    issue(3'b111, 32'd100,       32'd7,         5'd8,  32'd2);
    issue(3'b101, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF);
    issue(3'b111, 32'd5,         32'd0,         5'd10, 32'd5);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0);
    issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0);
    issue(3'b000, 32'd3,         32'd4,         5'd0,  32'd12);

    // START during CALC and on the DONE cycle must be ignored
    issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, 32'h0B00_EA4E);
    repeat (10) @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'b000;
    @(posedge CLK); #1; START = 1'b0;
    for (int i = 0; i < 60 && !DONE; i++) @(negedge CLK);
    check("done_seen", 64'(DONE), 64'(1));
    START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (40) @(negedge CLK);
    check("no_second_op", 64'(BUSY), 64'(0));

    // Reset mid-calculation aborts the op
    issue(3'b100, 32'd1000, 32'd3, 5'd15, 32'd333);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    void'(sb.pop_back());
    @(posedge CLK); #1;
    check("abort_busy",   64'(BUSY),   64'(0));
    check("abort_result", 64'(RESULT), 64'(0));
    check("abort_done",   64'(DONE),   64'(0));
    @(negedge CLK);
    RST = 1'b0;
    issue(3'b110, 32'hFFFF_FC18, 32'd7, 5'd16, 32'hFFFF_FFFA);

    // Random ops against the behavioural model
    for (int n = 0; n < 30; n++)
      issue_ref(3'($urandom), pick(), pick(), 5'($urandom));

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
    check("drain", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
